// File: rtl/cpu_pkg.sv
// Shared types and default constants for the front-panel memory loader.
package cpu_pkg;

    localparam int unsigned ADDR_W_DEFAULT  = 8;
    localparam int unsigned TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StFail = 2'd2
    } loader_state_e;

endpackage

// File: rtl/wait_timer.sv
// Cycle counter bounding how long a memory request may stay unacknowledged.
module wait_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !done) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    // Terminal count: the TIMEOUT-th waiting cycle is in progress.
    assign done = (count_q == LAST);

endmodule

// File: rtl/panel_loader.sv
// Front-panel loader: switch-entered address/data words written to processor memory.
module panel_loader
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Strobe,
    input  logic              Mode,
    input  logic [15:0]       SwData,
    output logic              MemReq,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [15:0]       MemWData,
    input  logic              MemAck,
    output logic              Busy,
    output logic [ADDR_W-1:0] AddrOut,
    output logic [15:0]       LastData,
    output logic              Error,
    output logic              Overrun
);

    loader_state_e state_q;
    logic          armed_q;
    logic          stb;
    logic          timer_clear;
    logic          timer_enable;
    logic          timer_done;

    // The first edge after reset release never acts on a strobe.
    assign stb          = Strobe && armed_q;
    assign timer_clear  = (state_q != StReq);
    assign timer_enable = (state_q == StReq) && !MemAck;
    assign MemAddr      = AddrOut;

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk    (Clock),
        .rst_n  (Resetn),
        .clear  (timer_clear),
        .enable (timer_enable),
        .done   (timer_done)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= StIdle;
            armed_q  <= 1'b0;
            MemReq   <= 1'b0;
            Busy     <= 1'b0;
            AddrOut  <= '0;
            MemWData <= '0;
            LastData <= '0;
            Error    <= 1'b0;
            Overrun  <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (stb && !Mode) begin
                        AddrOut <= SwData[ADDR_W-1:0];
                        Error   <= 1'b0;
                        Overrun <= 1'b0;
                    end else if (stb && Mode) begin
                        MemWData <= SwData;
                        state_q  <= StReq;
                        MemReq   <= 1'b1;
                        Busy     <= 1'b1;
                    end
                end
                StReq: begin
                    // An ack on the terminal cycle still completes the write.
                    if (MemAck) begin
                        state_q  <= StIdle;
                        MemReq   <= 1'b0;
                        Busy     <= 1'b0;
                        LastData <= MemWData;
                        AddrOut  <= AddrOut + ADDR_W'(1);
                    end else if (timer_done) begin
                        state_q <= StFail;
                        MemReq  <= 1'b0;
                        Error   <= 1'b1;
                    end
                    if (stb) Overrun <= 1'b1;
                end
                StFail: begin
                    state_q <= StIdle;
                    Busy    <= 1'b0;
                    if (stb) Overrun <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                    MemReq  <= 1'b0;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_panel_loader.sv
// Scenario bench for panel_loader with a write scoreboard.
module tb_panel_loader;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned TIMEOUT = 4;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic        Clock;
    logic        Resetn;
    logic        Strobe;
    logic        Mode;
    logic [15:0] SwData;
    logic        MemReq;
    logic [7:0]  MemAddr;
    logic [15:0] MemWData;
    logic        MemAck;
    logic        Busy;
    logic [7:0]  AddrOut;
    logic [15:0] LastData;
    logic        Error;
    logic        Overrun;

    int          checks   = 0;
    int          failures = 0;
    wr_t         sb_q[$];
    wr_t         exp_wr;
    logic [7:0]  exp_addr;
    logic [15:0] exp_last;

    panel_loader #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Strobe   (Strobe),
        .Mode     (Mode),
        .SwData   (SwData),
        .MemReq   (MemReq),
        .MemAddr  (MemAddr),
        .MemWData (MemWData),
        .MemAck   (MemAck),
        .Busy     (Busy),
        .AddrOut  (AddrOut),
        .LastData (LastData),
        .Error    (Error),
        .Overrun  (Overrun)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Called at a falling edge; returns at the falling edge after the strobe was sampled.
    task automatic strobe_once(input logic mode, input logic [15:0] data);
        Strobe = 1'b1;
        Mode   = mode;
        SwData = data;
        @(negedge Clock);
        Strobe = 1'b0;
        Mode   = 1'b0;
    endtask

    task automatic pop_and_compare(input string name);
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty, got addr=%h data=%h", name, MemAddr, MemWData);
        end else begin
            exp_wr = sb_q.pop_front();
            if (MemReq !== 1'b1 || MemAddr !== exp_wr.addr || MemWData !== exp_wr.data) begin
                failures++;
                $display("FAIL %s: got req=%b addr=%h data=%h, expected req=1 addr=%h data=%h",
                         name, MemReq, MemAddr, MemWData, exp_wr.addr, exp_wr.data);
            end
        end
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        Strobe = 1'b0;
        Mode   = 1'b0;
        SwData = '0;
        MemAck = 1'b0;
        repeat (2) @(negedge Clock);
        checks++;
        if ({MemReq, Busy, Error, Overrun} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: got req/busy/err/ovr=%b%b%b%b, expected 0000",
                     MemReq, Busy, Error, Overrun);
        end
        checks++;
        if (AddrOut !== 8'h00 || MemWData !== 16'h0000 || LastData !== 16'h0000) begin
            failures++;
            $display("FAIL reset_data: got addr=%h wdata=%h last=%h, expected 00 0000 0000",
                     AddrOut, MemWData, LastData);
        end
        // Strobe present on the first edge after release must be dropped.
        Resetn = 1'b1;
        strobe_once(1'b0, 16'h0055);
        checks++;
        if (AddrOut !== 8'h00) begin
            failures++;
            $display("FAIL reset_strobe_ignored: AddrOut=%h expected=00", AddrOut);
        end
        exp_addr = 8'h00;
        exp_last = 16'h0000;
    endtask

    task automatic test_addr_load();
        strobe_once(1'b0, 16'h0012);
        exp_addr = 8'h12;
        checks++;
        if (AddrOut !== exp_addr || MemAddr !== exp_addr || Busy !== 1'b0) begin
            failures++;
            $display("FAIL addr_load: got addr=%h memaddr=%h busy=%b, expected %h %h 0",
                     AddrOut, MemAddr, Busy, exp_addr, exp_addr);
        end
    endtask

    task automatic test_write_ack3();
        strobe_once(1'b1, 16'hBEEF);
        sb_q.push_back(wr_t'{exp_addr, 16'hBEEF});
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (MemReq !== 1'b1 || MemAddr !== 8'h12 || Busy !== 1'b1) begin
                failures++;
                $display("FAIL write_hold_%0d: got req=%b addr=%h busy=%b, expected 1 12 1",
                         c, MemReq, MemAddr, Busy);
            end
            @(negedge Clock);
        end
        MemAck = 1'b1;
        pop_and_compare("write_ack3_req");
        @(negedge Clock);
        MemAck   = 1'b0;
        exp_addr = exp_addr + 8'd1;
        exp_last = exp_wr.data;
        checks++;
        if (LastData !== exp_last || AddrOut !== exp_addr || MemReq !== 1'b0 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL write_ack3_done: got last=%h addr=%h req=%b busy=%b, expected %h %h 0 0",
                     LastData, AddrOut, MemReq, Busy, exp_last, exp_addr);
        end
    endtask

    task automatic test_wrap();
        strobe_once(1'b0, 16'h00FF);
        exp_addr = 8'hFF;
        checks++;
        if (AddrOut !== exp_addr) begin
            failures++;
            $display("FAIL wrap_load: AddrOut=%h expected=%h", AddrOut, exp_addr);
        end
        strobe_once(1'b1, 16'h1234);
        sb_q.push_back(wr_t'{exp_addr, 16'h1234});
        MemAck = 1'b1;
        pop_and_compare("wrap_req");
        @(negedge Clock);
        MemAck   = 1'b0;
        exp_addr = 8'h00;
        exp_last = 16'h1234;
        checks++;
        if (MemReq !== 1'b0 || AddrOut !== exp_addr || LastData !== exp_last) begin
            failures++;
            $display("FAIL wrap_done: got req=%b addr=%h last=%h, expected 0 %h %h",
                     MemReq, AddrOut, LastData, exp_addr, exp_last);
        end
        checks++;
        if (Error !== 1'b0 || Overrun !== 1'b0) begin
            failures++;
            $display("FAIL wrap_no_flag: got err=%b ovr=%b, expected 0 0", Error, Overrun);
        end
    endtask

    task automatic test_timeout();
        int n;
        strobe_once(1'b1, 16'hCAFE);
        n = 0;
        while (MemReq === 1'b1 && n < 20) begin
            n++;
            @(negedge Clock);
        end
        checks++;
        if (n != TIMEOUT) begin
            failures++;
            $display("FAIL timeout_req_cycles: got %0d, expected %0d", n, TIMEOUT);
        end
        checks++;
        if (Error !== 1'b1 || Busy !== 1'b1 || MemReq !== 1'b0) begin
            failures++;
            $display("FAIL timeout_fail_state: got err=%b busy=%b req=%b, expected 1 1 0",
                     Error, Busy, MemReq);
        end
        checks++;
        if (AddrOut !== exp_addr || LastData !== exp_last) begin
            failures++;
            $display("FAIL timeout_unchanged: got addr=%h last=%h, expected %h %h",
                     AddrOut, LastData, exp_addr, exp_last);
        end
        @(negedge Clock);
        checks++;
        if (Busy !== 1'b0 || Error !== 1'b1) begin
            failures++;
            $display("FAIL timeout_to_idle: got busy=%b err=%b, expected 0 1", Busy, Error);
        end
        strobe_once(1'b0, 16'h0040);
        exp_addr = 8'h40;
        checks++;
        if (Error !== 1'b0 || AddrOut !== exp_addr) begin
            failures++;
            $display("FAIL timeout_clear: got err=%b addr=%h, expected 0 %h", Error, AddrOut, exp_addr);
        end
    endtask

    task automatic test_overrun();
        strobe_once(1'b1, 16'h5A5A);
        sb_q.push_back(wr_t'{exp_addr, 16'h5A5A});
        Strobe = 1'b1;
        Mode   = 1'b1;
        SwData = 16'hFFFF;
        @(negedge Clock);
        Strobe = 1'b0;
        checks++;
        if (Overrun !== 1'b1 || MemWData !== 16'h5A5A || MemReq !== 1'b1) begin
            failures++;
            $display("FAIL overrun_set: got ovr=%b wdata=%h req=%b, expected 1 5a5a 1",
                     Overrun, MemWData, MemReq);
        end
        MemAck = 1'b1;
        pop_and_compare("overrun_req");
        @(negedge Clock);
        MemAck   = 1'b0;
        exp_addr = exp_addr + 8'd1;
        exp_last = exp_wr.data;
        checks++;
        if (AddrOut !== exp_addr || LastData !== exp_last || Overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_done: got addr=%h last=%h ovr=%b, expected %h %h 1",
                     AddrOut, LastData, Overrun, exp_addr, exp_last);
        end
        // Stray ack while idle.
        MemAck = 1'b1;
        @(negedge Clock);
        MemAck = 1'b0;
        checks++;
        if (AddrOut !== exp_addr || LastData !== exp_last || MemReq !== 1'b0 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_ack_ignored: got addr=%h last=%h req=%b busy=%b, expected %h %h 0 0",
                     AddrOut, LastData, MemReq, Busy, exp_addr, exp_last);
        end
    endtask

    task automatic test_reset_mid_req();
        strobe_once(1'b1, 16'h7777);
        checks++;
        if (MemReq !== 1'b1) begin
            failures++;
            $display("FAIL midreq_started: MemReq=%b expected=1", MemReq);
        end
        #2 Resetn = 1'b0;
        #1;
        checks++;
        if ({MemReq, Busy, Error, Overrun} !== 4'b0000) begin
            failures++;
            $display("FAIL midreq_reset_flags: got req/busy/err/ovr=%b%b%b%b, expected 0000",
                     MemReq, Busy, Error, Overrun);
        end
        checks++;
        if (AddrOut !== 8'h00 || MemAddr !== 8'h00 || MemWData !== 16'h0000 || LastData !== 16'h0000) begin
            failures++;
            $display("FAIL midreq_reset_data: got addr=%h memaddr=%h wdata=%h last=%h, expected zeros",
                     AddrOut, MemAddr, MemWData, LastData);
        end
        @(negedge Clock);
        Resetn = 1'b1;
        repeat (2) @(negedge Clock);
        checks++;
        if (MemReq !== 1'b0 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL midreq_after_release: got req=%b busy=%b, expected 0 0", MemReq, Busy);
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drained: %0d entries left, expected 0", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_addr_load();
        test_write_ack3();
        test_wrap();
        test_timeout();
        test_overrun();
        test_reset_mid_req();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
